// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock byte FIFO and its downstream word packer.
package fifo_pkg;

   localparam int unsigned FIFO_DW    = 8;
   localparam int unsigned FIFO_DEPTH = 64;

   typedef enum logic {
      ACC  = 1'b0,
      FULL = 1'b1
   } pack_state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Valid/ready word bus carrying packed words and their valid byte count.
interface fifo_word_packer_if
   import fifo_pkg::*;
#(
   parameter int unsigned WORD_BYTES = 4
);
   localparam int unsigned BW = clog2(WORD_BYTES + 1);

   logic                    m_valid;
   logic                    m_ready;
   logic [8*WORD_BYTES-1:0] m_data;
   logic [BW-1:0]           m_bytes;

   modport master (output m_valid, output m_data, output m_bytes, input m_ready);
   modport slave  (input m_valid, input m_data, input m_bytes, output m_ready);
endinterface

// File: rtl/fifo_idle_timer.sv
// Idle counter that raises a sticky expired flag after TIMEOUT_CYCLES counting cycles.
module fifo_idle_timer
   import fifo_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   input  logic clear,
   output logic expired
);
   localparam int unsigned CW = clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   // Saturates once expired; only clear restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (clear) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (count_en && !expired) begin
         cnt     <= cnt + CW'(1);
         expired <= (cnt == CW'(TIMEOUT_CYCLES - 1));
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains bytes from the FIFO and packs them little-endian into valid/ready words.
// Define PACKER_TIMEOUT_EN to flush partial words after TIMEOUT_CYCLES idle cycles.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int unsigned WORD_BYTES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fifo_empty,
   input  logic [FIFO_DW-1:0] fifo_data,
   output logic               fifo_rd_en,
   fifo_word_packer_if.master m
);
   localparam int unsigned BW = clog2(WORD_BYTES + 1);
   localparam int unsigned DW = 8 * WORD_BYTES;

   if (WORD_BYTES < 2 || WORD_BYTES > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("fifo_word_packer: WORD_BYTES must be 2..8 and TIMEOUT_CYCLES nonzero");
   end

   pack_state_t   state;
   logic [BW-1:0] acc_cnt;
   logic [DW-1:0] acc;
   logic          rd_pend;

   logic [DW-1:0] acc_fill;
   logic [BW-1:0] cnt_now;
   logic [BW-1:0] cnt_post;
   logic          out_free;
   logic          word_done;
   logic          xfer_full;
   logic          xfer_part;
   logic          xfer;

`ifdef PACKER_TIMEOUT_EN
   logic timer_expired;

   fifo_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_en (acc_cnt != '0 && acc_cnt < BW'(WORD_BYTES) && !rd_pend && fifo_empty),
      .clear    (fifo_rd_en || rd_pend || xfer || acc_cnt == '0),
      .expired  (timer_expired)
   );
`endif

   // Landing byte, transfer decision, and read issue on the post-transfer count.
   always_comb begin
      acc_fill = acc;
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
         if (rd_pend && acc_cnt == BW'(k)) acc_fill[8*k +: 8] = fifo_data;
      end
      cnt_now   = acc_cnt + BW'(rd_pend);
      out_free  = !m.m_valid || m.m_ready;
      word_done = (state == FULL) || (cnt_now == BW'(WORD_BYTES));
      xfer_full = out_free && word_done;
`ifdef PACKER_TIMEOUT_EN
      xfer_part = out_free && timer_expired && !rd_pend && (acc_cnt != '0) && !word_done;
`else
      xfer_part = 1'b0;
`endif
      xfer       = xfer_full || xfer_part;
      cnt_post   = xfer ? '0 : cnt_now;
      fifo_rd_en = rst_n && !fifo_empty && (cnt_post < BW'(WORD_BYTES));
   end

   // Accumulator and output register; accumulator is zeroed on transfer so unused bytes read 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= '0;
         acc_cnt   <= '0;
         rd_pend   <= 1'b0;
         m.m_valid <= 1'b0;
         m.m_data  <= '0;
         m.m_bytes <= '0;
      end else begin
         rd_pend <= fifo_rd_en;
         acc_cnt <= cnt_post;
         state   <= (cnt_post == BW'(WORD_BYTES)) ? FULL : ACC;
         acc     <= xfer ? '0 : acc_fill;
         if (xfer) begin
            m.m_valid <= 1'b1;
            m.m_data  <= acc_fill;
            m.m_bytes <= xfer_full ? BW'(WORD_BYTES) : acc_cnt;
         end else if (m.m_ready) begin
            m.m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer driven by a behavioural 64-deep byte FIFO.
module tb_fifo_word_packer;
   import fifo_pkg::*;

   localparam int unsigned WB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FIFO: registered read data, combinational empty.
   logic [7:0] fmem [0:FIFO_DEPTH-1];
   int         wptr = 0, rptr = 0, fcount = 0;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_data = 8'h00;
   logic       wr_en     = 1'b0;
   logic [7:0] wr_data   = 8'h00;
   logic       underflow = 1'b0;

   assign fifo_empty = (fcount == 0);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fcount == 0) underflow <= 1'b1;
         else begin
            fifo_data <= fmem[rptr];
            rptr      <= (rptr + 1) % FIFO_DEPTH;
         end
      end
      if (wr_en && fcount < FIFO_DEPTH) begin
         fmem[wptr] <= wr_data;
         wptr       <= (wptr + 1) % FIFO_DEPTH;
      end
      fcount <= fcount + ((wr_en && fcount < FIFO_DEPTH) ? 1 : 0)
                       - ((fifo_rd_en && fcount != 0) ? 1 : 0);
   end

   fifo_word_packer_if #(.WORD_BYTES(WB)) mif ();

   fifo_word_packer #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m          (mif)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [31:0] exp_d [$];
   logic [2:0]  exp_b [$];
   int vcyc = 0, rdc = 0, run = 0, maxrun = 0;

   // Monitor: pops the scoreboard on every accepted word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mif.m_valid) vcyc++;
         if (fifo_rd_en) begin
            rdc++;
            run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
         if (mif.m_valid && mif.m_ready) begin
            if (exp_d.size() == 0) check("unexp_valid", 64'(mif.m_valid), 64'd0);
            else begin
               check("word_data",  64'(mif.m_data),  64'(exp_d.pop_front()));
               check("word_bytes", 64'(mif.m_bytes), 64'(exp_b.pop_front()));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [2:0] b);
      exp_d.push_back(d);
      exp_b.push_back(b);
   endtask

   task automatic wait_drain(input int maxc);
      int i;
      i = 0;
      while (exp_d.size() != 0 && i < maxc) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("drain_left", 64'(exp_d.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] w;
      mif.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(mif.m_valid), 64'd0);
      check("rst_data",  64'(mif.m_data),  64'd0);
      check("rst_bytes", 64'(mif.m_bytes), 64'd0);
      check("rst_rd_en", 64'(fifo_rd_en),  64'd0);
      rst_n = 1'b1;
      idle(2);

      // single word
      vcyc = 0; maxrun = 0;
      expect_word(32'h44332211, 3'd4);
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
      wait_drain(20);
      idle(3);
      check("t1_valid_cycles", 64'(vcyc), 64'd1);
      check("t1_fifo_empty",   64'(fifo_empty), 64'd1);

      // 64-byte stream
      maxrun = 0;
      for (int i = 0; i < 64; i += 4) begin
         w = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
         expect_word(w, 3'd4);
      end
      for (int i = 0; i < 64; i++) write_byte(8'(i));
      wait_drain(40);
      idle(3);
      check("t2_rd_run", 64'(maxrun), 64'd64);

      // backpressure
      mif.m_ready = 1'b0;
      rdc = 0;
      for (int i = 0; i < 12; i += 4) begin
         w = {8'(8'h40 + i + 3), 8'(8'h40 + i + 2), 8'(8'h40 + i + 1), 8'(8'h40 + i)};
         expect_word(w, 3'd4);
      end
      for (int i = 0; i < 12; i++) write_byte(8'(8'h40 + i));
      idle(20);
      check("t3_reads_stalled", 64'(rdc), 64'd8);
      check("t3_hold_valid",    64'(mif.m_valid), 64'd1);
      check("t3_hold_data",     64'(mif.m_data), 64'h43424140);
      mif.m_ready = 1'b1;
      wait_drain(40);
      check("t3_reads_total", 64'(rdc), 64'd12);

      // empty throughout
      idle(3);
      rdc = 0;
      idle(10);
      check("t4_no_reads", 64'(rdc), 64'd0);
      check("t4_underflow", 64'(underflow), 64'd0);

      // partial word then idle
      vcyc = 0;
`ifdef PACKER_TIMEOUT_EN
      expect_word(32'h0000BBAA, 3'd2);
      write_byte(8'hAA); write_byte(8'hBB);
      idle(30);
      wait_drain(40);
`else
      write_byte(8'hAA); write_byte(8'hBB);
      idle(30);
      check("t5_no_valid", 64'(vcyc), 64'd0);
`endif
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // async reset with a held word and a partial accumulator
      mif.m_ready = 1'b0;
      for (int i = 1; i <= 7; i++) write_byte(8'(i));
      idle(12);
      check("t6_pre_valid", 64'(mif.m_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(mif.m_valid), 64'd0);
      check("t6_rst_data",  64'(mif.m_data),  64'd0);
      check("t6_rst_bytes", 64'(mif.m_bytes), 64'd0);
      check("t6_rst_rd_en", 64'(fifo_rd_en),  64'd0);
      idle(2);
      rst_n = 1'b1;
      mif.m_ready = 1'b1;
      idle(1);
      expect_word(32'hD3D2D1D0, 3'd4);
      write_byte(8'hD0); write_byte(8'hD1); write_byte(8'hD2); write_byte(8'hD3);
      wait_drain(20);
      idle(5);
      check("end_underflow", 64'(underflow), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
